btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_debounce.sv | 168 ++++++++++++++++
 tb/tb_btn_debounce.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer: 2-flop synchronizer, divided-clock sample
// tick, per-channel press/release acceptance FSM with optional auto-repeat.
module btn_debounce #(
    parameter int N_BTN        = 4,
    parameter int TICK_BIT     = 17,
    parameter int STABLE_TICKS = 4,
    parameter int REPEAT_TICKS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      clkdiv,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        HELD         = 2'd2,
        RELEASE_PEND = 2'd3
    } state_t;

    localparam logic [3:0] STABLE_LAST = 4'(STABLE_TICKS - 1);
    localparam logic [7:0] REPEAT_LAST = 8'(REPEAT_TICKS - 1);
    localparam logic       REPEAT_EN   = (REPEAT_TICKS != 0);

    logic [N_BTN-1:0] meta_r;
    logic [N_BTN-1:0] sync_r;
    logic             prev_r;
    logic             tick_s;

    state_t           state_r  [N_BTN];
    state_t           state_s  [N_BTN];
    logic [3:0]       stable_r [N_BTN];
    logic [3:0]       stable_s [N_BTN];
    logic [7:0]       rep_r    [N_BTN];
    logic [7:0]       rep_s    [N_BTN];
    logic [N_BTN-1:0] level_s;
    logic [N_BTN-1:0] press_s;
    logic [N_BTN-1:0] release_s;
    logic [N_BTN-1:0] repeat_s;

    // Synchronizer and tick-edge history; prev tracks clkdiv even in reset so
    // the first post-reset cycle cannot produce a spurious tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= {N_BTN{1'b0}};
            sync_r <= {N_BTN{1'b0}};
            prev_r <= clkdiv[TICK_BIT];
        end else begin
            meta_r <= btn_raw;
            sync_r <= meta_r;
            prev_r <= clkdiv[TICK_BIT];
        end
    end

    assign tick_s = clkdiv[TICK_BIT] & ~prev_r;

    // Per-channel next-state, counters and event decode.
    always_comb begin
        level_s   = {N_BTN{1'b0}};
        press_s   = {N_BTN{1'b0}};
        release_s = {N_BTN{1'b0}};
        repeat_s  = {N_BTN{1'b0}};
        for (int i = 0; i < N_BTN; i++) begin
            state_s[i]  = state_r[i];
            stable_s[i] = stable_r[i];
            rep_s[i]    = rep_r[i];
            if (tick_s) begin
                case (state_r[i])
                    RELEASED: begin
                        if (sync_r[i] && (STABLE_LAST == 4'd0)) begin
                            state_s[i]  = HELD;
                            stable_s[i] = 4'd0;
                            rep_s[i]    = 8'd0;
                            press_s[i]  = 1'b1;
                        end else if (sync_r[i]) begin
                            state_s[i]  = PRESS_PEND;
                            stable_s[i] = 4'd1;
                        end else begin
                            stable_s[i] = 4'd0;
                        end
                    end
                    PRESS_PEND: begin
                        if (!sync_r[i]) begin
                            state_s[i]  = RELEASED;
                            stable_s[i] = 4'd0;
                        end else if (stable_r[i] == STABLE_LAST) begin
                            state_s[i]  = HELD;
                            stable_s[i] = 4'd0;
                            rep_s[i]    = 8'd0;
                            press_s[i]  = 1'b1;
                        end else begin
                            stable_s[i] = stable_r[i] + 4'd1;
                        end
                    end
                    HELD: begin
                        if (!sync_r[i] && (STABLE_LAST == 4'd0)) begin
                            state_s[i]   = RELEASED;
                            stable_s[i]  = 4'd0;
                            release_s[i] = 1'b1;
                        end else if (!sync_r[i]) begin
                            state_s[i]  = RELEASE_PEND;
                            stable_s[i] = 4'd1;
                        end else if (REPEAT_EN && (rep_r[i] == REPEAT_LAST)) begin
                            rep_s[i]    = 8'd0;
                            repeat_s[i] = 1'b1;
                        end else if (REPEAT_EN) begin
                            rep_s[i] = rep_r[i] + 8'd1;
                        end else begin
                            rep_s[i] = 8'd0;
                        end
                    end
                    RELEASE_PEND: begin
                        // A bounce back to pressed resumes holding without any event.
                        if (sync_r[i]) begin
                            state_s[i]  = HELD;
                            stable_s[i] = 4'd0;
                            rep_s[i]    = 8'd0;
                        end else if (stable_r[i] == STABLE_LAST) begin
                            state_s[i]   = RELEASED;
                            stable_s[i]  = 4'd0;
                            release_s[i] = 1'b1;
                        end else begin
                            stable_s[i] = stable_r[i] + 4'd1;
                        end
                    end
                    default: begin
                        state_s[i]  = RELEASED;
                        stable_s[i] = 4'd0;
                        rep_s[i]    = 8'd0;
                    end
                endcase
            end else begin
                state_s[i] = state_r[i];
            end
            level_s[i] = (state_s[i] == HELD) || (state_s[i] == RELEASE_PEND);
        end
    end

    // Channel state registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_r[i]  <= RELEASED;
                stable_r[i] <= 4'd0;
                rep_r[i]    <= 8'd0;
            end
            btn_level   <= {N_BTN{1'b0}};
            btn_press   <= {N_BTN{1'b0}};
            btn_release <= {N_BTN{1'b0}};
            btn_repeat  <= {N_BTN{1'b0}};
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state_r[i]  <= state_s[i];
                stable_r[i] <= stable_s[i];
                rep_r[i]    <= rep_s[i];
            end
            btn_level   <= level_s;
            btn_press   <= press_s;
            btn_release <= release_s;
            btn_repeat  <= repeat_s;
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: two builds (repeat every 3 ticks, repeat disabled) driven
// by directed and random button activity, checked against a run-length reference model.
module tb_btn_debounce;
    localparam int NB = 4;
    localparam int ST = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   clkdiv;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] lvl_a, prs_a, rel_a, rep_a;
    logic [NB-1:0] lvl_b, prs_b, rel_b, rep_b;

    int total = 0;
    int bad   = 0;

    // reference model: shared sample run-length per channel, per-build level/repeat
    int            rep_cfg [2] = '{3, 0};
    logic [NB-1:0] m_level [2];
    int            m_rep   [2][NB];
    logic          m_run_val [NB];
    int            m_run_len [NB];
    logic [NB-1:0] exp_prs [2];
    logic [NB-1:0] exp_rel [2];
    logic [NB-1:0] exp_rep [2];
    logic [NB-1:0] s1, s2;
    logic          m_prev;
    logic [31:0]   cd;

    // observed pulse tallies
    int cnt_prs [NB];
    int cnt_rel [NB];
    int cnt_rep_a;
    int cnt_rep_b;

    always #5 clk = ~clk;

    btn_debounce #(.N_BTN(NB), .TICK_BIT(2), .STABLE_TICKS(ST), .REPEAT_TICKS(3)) dut (
        .clk(clk), .rst(rst), .clkdiv(clkdiv), .btn_raw(btn_raw),
        .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a), .btn_repeat(rep_a)
    );

    btn_debounce #(.N_BTN(NB), .TICK_BIT(2), .STABLE_TICKS(ST), .REPEAT_TICKS(0)) dut_norep (
        .clk(clk), .rst(rst), .clkdiv(clkdiv), .btn_raw(btn_raw),
        .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b), .btn_repeat(rep_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        s1 = '0;
        s2 = '0;
        for (int c = 0; c < 2; c++) begin
            m_level[c] = '0;
            exp_prs[c] = '0;
            exp_rel[c] = '0;
            exp_rep[c] = '0;
            for (int ch = 0; ch < NB; ch++) m_rep[c][ch] = 0;
        end
        for (int ch = 0; ch < NB; ch++) begin
            m_run_val[ch] = 1'b0;
            m_run_len[ch] = 0;
        end
    endfunction

    // A level flips once the last ST samples all disagree with it; repeats count
    // consecutive pressed samples that follow a pressed sample while held.
    function automatic void model_tick(input int ch, input logic s);
        logic same;
        same = (m_run_len[ch] > 0) && (m_run_val[ch] == s);
        if (same) begin
            if (m_run_len[ch] < 1000) m_run_len[ch]++;
        end else begin
            m_run_val[ch] = s;
            m_run_len[ch] = 1;
        end
        for (int c = 0; c < 2; c++) begin
            if (!m_level[c][ch]) begin
                if (s && m_run_len[ch] >= ST) begin
                    m_level[c][ch] = 1'b1;
                    exp_prs[c][ch] = 1'b1;
                    m_rep[c][ch]   = 0;
                end
            end else if (s) begin
                if (!same) begin
                    m_rep[c][ch] = 0;
                end else if (rep_cfg[c] != 0) begin
                    m_rep[c][ch]++;
                    if (m_rep[c][ch] == rep_cfg[c]) begin
                        exp_rep[c][ch] = 1'b1;
                        m_rep[c][ch]   = 0;
                    end
                end
            end else if (m_run_len[ch] >= ST) begin
                m_level[c][ch] = 1'b0;
                exp_rel[c][ch] = 1'b1;
            end
        end
    endfunction

    // One clock: mirror the edge in the model, compare outputs, advance clkdiv.
    task automatic step();
        logic          tick;
        logic [NB-1:0] smp;
        @(posedge clk);
        if (rst) begin
            m_prev = clkdiv[2];
            model_reset();
        end else begin
            tick   = clkdiv[2] && !m_prev;
            m_prev = clkdiv[2];
            smp    = s2;
            s2     = s1;
            s1     = btn_raw;
            for (int c = 0; c < 2; c++) begin
                exp_prs[c] = '0;
                exp_rel[c] = '0;
                exp_rep[c] = '0;
            end
            if (tick) begin
                for (int ch = 0; ch < NB; ch++) model_tick(ch, smp[ch]);
            end
        end
        #1;
        check_val("level_a",   32'(lvl_a), 32'(m_level[0]));
        check_val("press_a",   32'(prs_a), 32'(exp_prs[0]));
        check_val("release_a", 32'(rel_a), 32'(exp_rel[0]));
        check_val("repeat_a",  32'(rep_a), 32'(exp_rep[0]));
        check_val("level_b",   32'(lvl_b), 32'(m_level[1]));
        check_val("press_b",   32'(prs_b), 32'(exp_prs[1]));
        check_val("release_b", 32'(rel_b), 32'(exp_rel[1]));
        check_val("repeat_b",  32'(rep_b), 32'(exp_rep[1]));
        for (int ch = 0; ch < NB; ch++) begin
            if (prs_a[ch]) cnt_prs[ch]++;
            if (rel_a[ch]) cnt_rel[ch]++;
        end
        if (rep_a != '0) cnt_rep_a++;
        if (rep_b != '0) cnt_rep_b++;
        cd     = cd + 32'd1;
        clkdiv = cd;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_counts();
        for (int ch = 0; ch < NB; ch++) begin
            cnt_prs[ch] = 0;
            cnt_rel[ch] = 0;
        end
    endtask

    initial begin
        cnt_rep_a = 0;
        cnt_rep_b = 0;
        clear_counts();
        model_reset();
        m_prev  = 1'b0;
        rst     = 1'b1;
        btn_raw = 4'hF;
        cd      = 32'd3;
        clkdiv  = cd;

        // reset for 3 clocks, released while clkdiv[2] is high
        run(3);
        rst = 1'b0;
        run(40);
        check_val("lvl_after_rst", 32'(lvl_a), 32'h0000000F);
        check_val("press_after_rst", 32'(cnt_prs[0] + cnt_prs[1] + cnt_prs[2] + cnt_prs[3]), 32'd4);
        run(30);

        // release everything
        btn_raw = 4'h0;
        run(60);
        check_val("lvl_all_released", 32'(lvl_a), 32'h00000000);

        // btn0 steady press, btn1 toggles every tick
        clear_counts();
        btn_raw[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            btn_raw[1] = ~btn_raw[1];
            run(8);
        end
        check_val("bounce_no_press1", 32'(cnt_prs[1]), 32'd0);
        check_val("bounce_lvl1", 32'(lvl_a[1]), 32'd0);
        check_val("btn0_pressed_once", 32'(cnt_prs[0]), 32'd1);
        run(24);

        // short release glitch on held btn0, then a real release
        clear_counts();
        btn_raw[0] = 1'b0;
        run(16);
        btn_raw[0] = 1'b1;
        run(24);
        check_val("glitch_lvl0", 32'(lvl_a[0]), 32'd1);
        check_val("glitch_no_release0", 32'(cnt_rel[0]), 32'd0);
        btn_raw[0] = 1'b0;
        run(48);
        check_val("release_lvl0", 32'(lvl_a[0]), 32'd0);
        check_val("release_once0", 32'(cnt_rel[0]), 32'd1);

        // reset while btn2 held, still held afterwards
        btn_raw[2] = 1'b1;
        run(48);
        check_val("btn2_held", 32'(lvl_a[2]), 32'd1);
        clear_counts();
        rst = 1'b1;
        run(1);
        check_val("rst_drops_lvl2", 32'(lvl_a[2]), 32'd0);
        run(1);
        rst = 1'b0;
        run(48);
        check_val("btn2_fresh_press", 32'(cnt_prs[2]), 32'd1);
        check_val("btn2_no_release", 32'(cnt_rel[2]), 32'd0);
        check_val("btn2_relevel", 32'(lvl_a[2]), 32'd1);

        // random activity with occasional resets
        for (int seg = 0; seg < 150; seg++) begin
            if ($urandom_range(0, 24) == 0) begin
                rst = 1'b1;
                run($urandom_range(1, 3));
                rst = 1'b0;
            end
            btn_raw = btn_raw ^ (4'($urandom_range(0, 15)) & 4'($urandom));
            run($urandom_range(4, 80));
        end

        check_val("norep_never", 32'(cnt_rep_b), 32'd0);
        check_val("rep_seen", 32'(cnt_rep_a != 0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
